fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Controller that sequences instruction fetch between the PC/fetch datapath and the instruction memory port.
- Keeps the fetch PC and issues one request at a time over a req/gnt/rvalid handshake. Buffers returned words in a 2-entry instruction queue for decode.
- Handles control-flow redirects (taken branch, JAL, JALR) by flushing the queue and discarding any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, fetch address issued first after reset release (bits [1:0] must be 0)
QDEPTH, 2, instruction queue depth (fixed at 2; other values unsupported)

Ports:
clk_i  in  1  clock, rising edge
PCrst_i  in  1  asynchronous, active-low reset
redir_valid_i  in  1  one-cycle redirect pulse from branch/jump resolution
redir_pc_i  in  32  redirect target; bits [1:0] ignored (forced to 0)
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  fetch address, word aligned
imem_gnt_i  in  1  memory accepts request this cycle (req & gnt = handshake)
imem_rvalid_i  in  1  response valid, at least 1 cycle after gnt
imem_rdata_i  in  32  instruction word
instr_valid_o  out  1  queue head valid
instr_o  out  32  queue head instruction
instr_pc_o  out  32  PC of queue head
instr_ready_i  in  1  decode consumes head when instr_valid_o & instr_ready_i
busy_o  out  1  request outstanding (WAIT or DRAIN)

Behaviour:
- Reset (PCrst_i=0, async): fetch_pc=RESET_PC, state=IDLE, queue empty.
  - Outputs during reset: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, busy_o=0.
  - Reset asserted mid-transaction aborts it; a later rvalid for the aborted request is not expected and is ignored in IDLE.
- States: IDLE, REQ, WAIT, DRAIN.
  - IDLE -> REQ on the first clock after reset release.
  - REQ: imem_req_o=1, imem_addr_o=fetch_pc.
    - Enter REQ only when queue_count + outstanding < 2.
    - Otherwise hold in IDLE with imem_req_o=0.
    - On gnt: fetch_pc <= fetch_pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0), tag_pc <= fetch_pc, go to WAIT.
  - WAIT: imem_req_o=0, busy_o=1. On rvalid: push {tag_pc, rdata}; go to REQ if space remains after the push/pop of this cycle, else IDLE.
  - DRAIN: busy_o=1, imem_req_o=0. On rvalid: discard the data, go to REQ.
- Redirect has highest priority and is evaluated at the same edge as the events below.
  - The queue is flushed at that edge; instr_valid_o=0 the next cycle.
  - fetch_pc <= {redir_pc_i[31:2],2'b00}.
  - In REQ without gnt: stay in REQ. The next cycle presents the new address (req stays 1).
  - In REQ with gnt in the same cycle: the granted request is stale; go to DRAIN.
  - In WAIT without rvalid: go to DRAIN.
  - In WAIT with rvalid in the same cycle: data discarded, go to REQ.
  - In DRAIN: stay in DRAIN, keeping the newest target.
  - In IDLE: go to REQ.
- Queue: 2-entry FIFO with registered head outputs.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pop when empty: no effect.
  - Push when full: cannot occur, guaranteed by the issue rule. Assertion required.
  - A push at edge M makes the entry visible on instr_valid_o in cycle M+1. No bypass.
- Latency: from a gnt at cycle N and rvalid at cycle N+1, the instruction is at the head in cycle N+2. Steady state (gnt same cycle, rvalid +1) is one instruction every 2 cycles with one outstanding request.
- instr_o and instr_pc_o hold their last value when instr_valid_o=0 (0 after reset).

Test Plan:
- Reset release, memory always grants, rvalid 1 cycle after gnt, ready=1:
  - addresses issued are 0x0, 0x4, 0x8.
  - instr_pc_o sequence is 0x0, 0x4, 0x8 with matching rdata.
  - first instr_valid_o occurs 3 cycles after reset release.
- ready=0 backpressure:
  - after 2 pushes, instr_valid_o=1 with head pc 0x0; imem_req_o stays 0 and busy_o=0.
  - raising ready for one cycle pops 0x0, then one new request (addr 0x8) issues.
- Redirect to 0x100 in WAIT:
  - queue flushed; state becomes DRAIN.
  - the response for 0x8 is dropped and never appears on instr_o.
  - the next request address is 0x100; the first delivered instr_pc_o is 0x100.
- Redirect to 0x203 coincident with gnt:
  - DRAIN, then request 0x200.
  - redirect coincident with rvalid: data discarded, next request at the target.
- Wrap-around and reset:
  - RESET_PC=0xFFFF_FFFC gives requests at 0xFFFF_FFFC then 0x0.
  - asserting PCrst_i in WAIT immediately drops imem_req_o/instr_valid_o to 0.
  - after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: keeps the fetch PC, issues one request at a
// time over a req/gnt/rvalid handshake and buffers returned words in a
// 2-entry queue whose head is presented to decode from registers.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        PCrst_i,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        busy_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [1:0] QFULL = 2'(QDEPTH);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] tag_pc;
    logic [31:0] redir_target;
    logic [1:0]  count;
    logic [1:0]  count_nxt;
    logic [31:0] slot0_data;
    logic [31:0] slot0_pc;
    logic [31:0] slot1_data;
    logic [31:0] slot1_pc;
    logic        grant;
    logic        push;
    logic        pop;

    assign redir_target = redir_pc_i & 32'hFFFF_FFFC;
    assign grant        = (state == REQ) && imem_gnt_i;
    // A response landing together with a redirect belongs to the old path.
    assign push         = (state == WAIT) && imem_rvalid_i && !redir_valid_i;
    assign pop          = (count != 2'd0) && instr_ready_i;

    assign imem_req_o    = (state == REQ);
    assign imem_addr_o   = fetch_pc;
    assign busy_o        = (state == WAIT) || (state == DRAIN);
    assign instr_valid_o = (count != 2'd0);
    assign instr_o       = slot0_data;
    assign instr_pc_o    = slot0_pc;

    // Queue occupancy after this cycle's push/pop, or zero on a flush.
    always_comb begin
        count_nxt = count;
        if (redir_valid_i) begin
            count_nxt = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + 2'd1;
                2'b01:   count_nxt = count - 2'd1;
                default: count_nxt = count;
            endcase
        end
    end

    // Next-state logic; a redirect overrides every other event this cycle.
    always_comb begin
        state_nxt = state;
        if (redir_valid_i) begin
            case (state)
                IDLE:    state_nxt = REQ;
                REQ:     state_nxt = imem_gnt_i ? DRAIN : REQ;
                WAIT:    state_nxt = imem_rvalid_i ? REQ : DRAIN;
                // The stale response still has to be absorbed; if it arrives
                // now it is gone and the new target can be requested.
                default: state_nxt = imem_rvalid_i ? REQ : DRAIN;
            endcase
        end else begin
            case (state)
                IDLE:    state_nxt = (count_nxt < QFULL) ? REQ : IDLE;
                REQ:     state_nxt = imem_gnt_i ? WAIT : REQ;
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state_nxt = (count_nxt < QFULL) ? REQ : IDLE;
                    end
                end
                default: state_nxt = imem_rvalid_i ? REQ : DRAIN;
            endcase
        end
    end

    // Control state, fetch PC and queue occupancy.
    always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            count    <= 2'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (redir_valid_i) begin
                fetch_pc <= redir_target;
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // Remember which address the outstanding request was issued for.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            tag_pc <= fetch_pc;
        end
    end

    // Queue head: shifts from slot1 on pop, loads directly when it would be empty.
    always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) begin
            slot0_data <= 32'd0;
            slot0_pc   <= 32'd0;
        end else if (pop && (count == 2'd2)) begin
            slot0_data <= slot1_data;
            slot0_pc   <= slot1_pc;
        end else if (push && ((count == 2'd0) || (pop && (count == 2'd1)))) begin
            slot0_data <= imem_rdata_i;
            slot0_pc   <= tag_pc;
        end
    end

    // Second queue entry, written when the head is still occupied afterwards.
    always_ff @(posedge clk_i) begin
        if (push && (((count == 2'd1) && !pop) || ((count == 2'd2) && pop))) begin
            slot1_data <= imem_rdata_i;
            slot1_pc   <= tag_pc;
        end
    end

`ifndef SYNTHESIS
    // The issue rule must never let a response arrive into a full queue.
    always @(posedge clk_i) begin
        if (PCrst_i) begin
            assert (!(push && (count == QFULL) && !pop))
                else $error("fetch_sequencer: push into full instruction queue");
        end
    end
`endif

endmodule
